// File: rtl/uart_rx_if.sv
// Receiver-side UART signal bundle: line input, frame config and the received-byte result.
// master = register block / line driver, slave = uart_rx.
interface uart_rx_if;
    logic       rx_en;
    logic [1:0] parity_type;
    logic       nstop;
    logic       rxd;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       frame_error;
    logic       rx_busy;

    modport master (
        output rx_en, parity_type, nstop, rxd,
        input  data_out, data_valid, parity_error, frame_error, rx_busy
    );

    modport slave (
        input  rx_en, parity_type, nstop, rxd,
        output data_out, data_valid, parity_error, frame_error, rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: one bit per clock, start + 8 data LSB-first + optional parity + 1/2 stop bits.
// Latency: data_valid pulses for one cycle right after the final stop-bit sample edge.
// No backpressure: the byte and flags are held until the next frame, and the pulse is not repeated.
module uart_rx (
    input  logic clock,
    input  logic reset,
    uart_rx_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t     present_state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [1:0] cfg_parity;
    logic       cfg_nstop;
    logic       pend_parity;
    logic       pend_frame;

    logic [7:0] data_out_q;
    logic       data_valid_q;
    logic       parity_error_q;
    logic       frame_error_q;
    logic       rx_busy_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            present_state  <= IDLE;
            bit_cnt        <= 3'd0;
            shift_reg      <= 8'd0;
            cfg_parity     <= 2'd0;
            cfg_nstop      <= 1'b0;
            pend_parity    <= 1'b0;
            pend_frame     <= 1'b0;
            data_out_q     <= 8'd0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
            rx_busy_q      <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            case (present_state)
                IDLE: begin
                    // Config is captured at the start sample so mid-frame changes cannot corrupt it
                    if (bus.rx_en && !bus.rxd) begin
                        present_state <= DATA;
                        bit_cnt       <= 3'd0;
                        cfg_parity    <= bus.parity_type;
                        cfg_nstop     <= bus.nstop;
                        pend_parity   <= 1'b0;
                        pend_frame    <= 1'b0;
                        rx_busy_q     <= 1'b1;
                    end
                end
                DATA: begin
                    shift_reg[bit_cnt] <= bus.rxd;
                    bit_cnt            <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        present_state <= cfg_parity[1] ? PARITY : STOP1;
                end
                PARITY: begin
                    if (bus.rxd != (^shift_reg ^ cfg_parity[0]))
                        pend_parity <= 1'b1;
                    present_state <= STOP1;
                end
                STOP1: begin
                    if (cfg_nstop) begin
                        pend_frame    <= pend_frame | ~bus.rxd;
                        present_state <= STOP2;
                    end else begin
                        data_out_q     <= shift_reg;
                        parity_error_q <= pend_parity;
                        frame_error_q  <= pend_frame | ~bus.rxd;
                        data_valid_q   <= 1'b1;
                        pend_parity    <= 1'b0;
                        pend_frame     <= 1'b0;
                        rx_busy_q      <= 1'b0;
                        present_state  <= IDLE;
                    end
                end
                STOP2: begin
                    data_out_q     <= shift_reg;
                    parity_error_q <= pend_parity;
                    frame_error_q  <= pend_frame | ~bus.rxd;
                    data_valid_q   <= 1'b1;
                    pend_parity    <= 1'b0;
                    pend_frame     <= 1'b0;
                    rx_busy_q      <= 1'b0;
                    present_state  <= IDLE;
                end
                default: begin
                    present_state <= IDLE;
                    rx_busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.parity_error = parity_error_q;
    assign bus.frame_error  = frame_error_q;
    assign bus.rx_busy      = rx_busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives serial frames bit-per-clock and checks byte, flags and timing.
module tb_uart_rx;
    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   busy_cnt;
    int   dv_cnt;

    uart_rx_if u_if ();

    uart_rx dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one frame; on return we sit #1 after the final stop-sample edge.
    task automatic drive_frame(input logic [7:0] d, input logic [1:0] pt, input logic ns,
                               input logic par_bit, input logic s1, input logic s2,
                               input int drop_en_at);
        logic [11:0] seq;
        int          n;
        seq      = '0;
        seq[0]   = 1'b0;
        seq[8:1] = d;
        n        = 9;
        if (pt[1]) begin seq[n] = par_bit; n++; end
        seq[n] = s1; n++;
        if (ns) begin seq[n] = s2; n++; end
        u_if.parity_type = pt;
        u_if.nstop       = ns;
        busy_cnt = 0;
        dv_cnt   = 0;
        for (int i = 0; i < n; i++) begin
            u_if.rxd = seq[i];
            tick();
            if (i == 0) begin
                u_if.parity_type = ~pt;
                u_if.nstop       = ~ns;
            end
            if (i == drop_en_at) u_if.rx_en = 1'b0;
            if (u_if.rx_busy) busy_cnt++;
            if (u_if.data_valid) dv_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        u_if.rxd = 1'b1;
        u_if.rx_en = 1'b0;
        u_if.parity_type = 2'b00;
        u_if.nstop = 1'b0;
        tick();
        reset = 1'b0;
        total++; if (u_if.data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out got=%h exp=00", u_if.data_out); end
        total++; if (u_if.data_valid !== 1'b0) begin bad++; $display("FAIL reset_data_valid got=%b exp=0", u_if.data_valid); end
        total++; if (u_if.parity_error !== 1'b0) begin bad++; $display("FAIL reset_parity_error got=%b exp=0", u_if.parity_error); end
        total++; if (u_if.frame_error !== 1'b0) begin bad++; $display("FAIL reset_frame_error got=%b exp=0", u_if.frame_error); end
        total++; if (u_if.rx_busy !== 1'b0) begin bad++; $display("FAIL reset_rx_busy got=%b exp=0", u_if.rx_busy); end
        total++; if (dut.present_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dut.present_state); end
        u_if.rx_en = 1'b1;
        tick();
    endtask

    task automatic test_8n1();
        drive_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        total++; if (u_if.data_valid !== 1'b1) begin bad++; $display("FAIL 8n1_valid_after_e9 got=%b exp=1", u_if.data_valid); end
        total++; if (dv_cnt !== 1) begin bad++; $display("FAIL 8n1_valid_count got=%0d exp=1", dv_cnt); end
        total++; if (u_if.data_out !== 8'hA5) begin bad++; $display("FAIL 8n1_data got=%h exp=a5", u_if.data_out); end
        total++; if (u_if.parity_error !== 1'b0 || u_if.frame_error !== 1'b0) begin
            bad++; $display("FAIL 8n1_flags got=%b%b exp=00", u_if.parity_error, u_if.frame_error); end
        total++; if (busy_cnt !== 9) begin bad++; $display("FAIL 8n1_busy_cycles got=%0d exp=9", busy_cnt); end
        u_if.rxd = 1'b1;
        tick();
        total++; if (u_if.data_valid !== 1'b0) begin bad++; $display("FAIL 8n1_valid_one_cycle got=%b exp=0", u_if.data_valid); end
        total++; if (u_if.data_out !== 8'hA5) begin bad++; $display("FAIL 8n1_data_hold got=%h exp=a5", u_if.data_out); end
    endtask

    task automatic test_parity();
        drive_frame(8'h3C, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, -1);
        total++; if (u_if.data_valid !== 1'b1 || dv_cnt !== 1) begin
            bad++; $display("FAIL 8o2_valid_after_e11 got=%b/%0d exp=1/1", u_if.data_valid, dv_cnt); end
        total++; if (busy_cnt !== 11) begin bad++; $display("FAIL 8o2_busy_cycles got=%0d exp=11", busy_cnt); end
        total++; if (u_if.data_out !== 8'h3C || u_if.parity_error !== 1'b0) begin
            bad++; $display("FAIL 8o2_good got=%h pe=%b exp=3c pe=0", u_if.data_out, u_if.parity_error); end
        drive_frame(8'h3C, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        total++; if (u_if.parity_error !== 1'b1) begin bad++; $display("FAIL 8o2_bad_parity got=%b exp=1", u_if.parity_error); end
        total++; if (u_if.data_out !== 8'h3C || u_if.frame_error !== 1'b0) begin
            bad++; $display("FAIL 8o2_bad_data got=%h fe=%b exp=3c fe=0", u_if.data_out, u_if.frame_error); end
    endtask

    task automatic test_frame_error();
        drive_frame(8'h5A, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        total++; if (u_if.data_valid !== 1'b1 || u_if.frame_error !== 1'b1) begin
            bad++; $display("FAIL fe_set got=dv%b fe%b exp=dv1 fe1", u_if.data_valid, u_if.frame_error); end
        total++; if (u_if.parity_error !== 1'b0 || u_if.data_out !== 8'h5A) begin
            bad++; $display("FAIL fe_data got=%h pe=%b exp=5a pe=0", u_if.data_out, u_if.parity_error); end
        u_if.rxd = 1'b1;
        tick();
        total++; if (u_if.rx_busy !== 1'b0 || dut.present_state !== 3'd0) begin
            bad++; $display("FAIL fe_idle got=busy%b st%0d exp=busy0 st0", u_if.rx_busy, dut.present_state); end
        drive_frame(8'h00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        total++; if (u_if.data_out !== 8'h00 || u_if.frame_error !== 1'b0 || u_if.parity_error !== 1'b0) begin
            bad++; $display("FAIL fe_clear got=%h pe%b fe%b exp=00 pe0 fe0", u_if.data_out, u_if.parity_error, u_if.frame_error); end
        u_if.rxd = 1'b1;
        tick();
    endtask

    task automatic test_enable();
        int dv = 0;
        int bz = 0;
        u_if.rx_en = 1'b0;
        u_if.rxd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (u_if.data_valid) dv++;
            if (u_if.rx_busy) bz++;
        end
        total++; if (dv !== 0 || bz !== 0) begin bad++; $display("FAIL en_off_idle got=dv%0d busy%0d exp=0 0", dv, bz); end
        u_if.rxd = 1'b1;
        u_if.rx_en = 1'b1;
        tick();
        // 0x81 has even weight, so parity bit 1 is wrong for even parity; stop also 0
        drive_frame(8'h81, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 3);
        total++; if (u_if.data_valid !== 1'b1 || dv_cnt !== 1 || u_if.data_out !== 8'h81) begin
            bad++; $display("FAIL en_drop_mid got=dv%b n%0d d%h exp=dv1 n1 d81", u_if.data_valid, dv_cnt, u_if.data_out); end
        total++; if (u_if.parity_error !== 1'b1 || u_if.frame_error !== 1'b1) begin
            bad++; $display("FAIL en_drop_flags got=pe%b fe%b exp=pe1 fe1", u_if.parity_error, u_if.frame_error); end
        u_if.rxd = 1'b1;
        u_if.rx_en = 1'b1;
        tick();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        int dv = 0;
        d = 8'hC3;
        u_if.parity_type = 2'b00;
        u_if.nstop = 1'b0;
        u_if.rxd = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            u_if.rxd = d[i];
            tick();
        end
        reset = 1'b1;
        u_if.rxd = d[3];
        tick();
        reset = 1'b0;
        total++; if (u_if.data_out !== 8'h00 || u_if.data_valid !== 1'b0) begin
            bad++; $display("FAIL rst_mid_out got=%h dv%b exp=00 dv0", u_if.data_out, u_if.data_valid); end
        total++; if (u_if.parity_error !== 1'b0 || u_if.frame_error !== 1'b0 || u_if.rx_busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid_flags got=pe%b fe%b busy%b exp=000", u_if.parity_error, u_if.frame_error, u_if.rx_busy); end
        u_if.rxd = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (u_if.data_valid) dv++;
        end
        total++; if (dv !== 0) begin bad++; $display("FAIL rst_mid_no_valid got=%0d exp=0", dv); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic [1:0] pt;
        logic       ns;
        int         errs = 0;
        u_if.rx_en = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            d  = 8'($urandom_range(0, 255));
            pt = 2'($urandom_range(0, 3));
            ns = 1'($urandom_range(0, 1));
            drive_frame(d, pt, ns, ^d ^ pt[0], 1'b1, 1'b1, -1);
            total++;
            if (u_if.data_valid !== 1'b1 || dv_cnt !== 1 || u_if.data_out !== d ||
                u_if.parity_error !== 1'b0 || u_if.frame_error !== 1'b0) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL b2b_frame%0d got=dv%b n%0d d%h pe%b fe%b exp=dv1 n1 d%h pe0 fe0",
                             k, u_if.data_valid, dv_cnt, u_if.data_out, u_if.parity_error, u_if.frame_error, d);
            end
        end
        u_if.rxd = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_frame_error();
        test_enable();
        test_reset_midframe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
